// File: rtl/spi_frame_rx.sv
// Purpose: SPI mode-0 slave that receives one fixed-length frame per cs window and returns a response frame on miso.
// Latency: frame_valid rises SYNC_STAGES+2 clk after cs deasserts; err pulses land on that same clk edge.
// Backpressure: a frame waits in HOLD until frame_ready; a new cs window arriving during HOLD is ignored and flagged on err[2].
//
// Ports:
//   clk, reset (async, active-low)
//   cs, sclk, mosi   : SPI inputs, asynchronous to clk
//   miso             : SPI output, MSB first, 0 outside SHIFT
//   tx_data          : response frame, captured when a frame starts
//   frame_data/frame_valid/frame_ready : received-frame handshake
//   busy             : high in SHIFT and CHECK
//   err              : one-cycle pulses [0] short frame, [1] long frame, [2] overrun
// Build option: define SPI_FRAME_RX_KEYCHK_EN to reject frames whose key_size
// field is not 0x10, 0x18 or 0x20 (rejection is reported as err[0]).

module spi_frame_rx #(
    parameter int FRAME_BITS  = 392,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  busy,
    output logic [2:0]            err
);

    localparam logic [8:0] FULL_CNT = 9'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers; reset to the bus idle levels so that leaving
    // reset never looks like an edge on its own.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sclk_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync[0]   <= cs;
            sclk_sync[0] <= sclk;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]   <= cs_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            cs_d   <= cs_sync[SYNC_STAGES-1];
            sclk_d <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t                state, state_nxt;
    logic [8:0]            bit_cnt;
    logic                  long_flag;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [2:0]            err_nxt;
    logic                  accept;
    logic                  key_ok;

`ifdef SPI_FRAME_RX_KEYCHK_EN
    // key_size sits directly below the 128-bit text field.
    logic [7:0] key_size;
    assign key_size = rx_sr[FRAME_BITS-129 -: 8];
    assign key_ok   = (key_size == 8'h10) || (key_size == 8'h18) || (key_size == 8'h20);
`else
    assign key_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                // Any sclk edge in this same cycle is still applied by the datapath.
                if (cs_rise) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = IDLE;
                if (bit_cnt < FULL_CNT) begin
                    err_nxt[0] = 1'b1;
                end else if (long_flag) begin
                    err_nxt[1] = 1'b1;
                end else if (!key_ok) begin
                    err_nxt[0] = 1'b1;
                end else begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A cs window opened here has no falling edge left to start from
                // once we return to IDLE, so it is ignored until cs rises again.
                if (cs_fall)     err_nxt[2] = 1'b1;
                if (frame_ready) state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            long_flag  <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            frame_data <= '0;
            err        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt   <= '0;
                        long_flag <= 1'b0;
                        rx_sr     <= '0;
                        tx_sr     <= tx_data;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt == FULL_CNT) begin
                            long_flag <= 1'b1;
                        end else begin
                            rx_sr   <= {rx_sr[FRAME_BITS-2:0], mosi_s};
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
            if (accept) frame_data <= rx_sr;
            err <= err_nxt;
        end
    end

    assign frame_valid = (state == HOLD);
    assign busy        = (state == SHIFT) || (state == CHECK);
    assign miso        = (state == SHIFT) & tx_sr[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed and randomized frames against a bit-level outcome model: the bench
// decides from bit count and key_size alone whether a frame should be
// accepted, rejected short, or rejected long, and what miso must carry.

module tb_spi_frame_rx;

    localparam int FB = 392;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic [FB-1:0] tx_data = '0;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic          busy;
    logic [2:0]    err;

    spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    int   ec0 = 0, ec1 = 0, ec2 = 0, vrise = 0;
    logic vld_prev = 1'b0;
    always @(negedge clk) begin
        if (err[0]) ec0 <= ec0 + 1;
        if (err[1]) ec1 <= ec1 + 1;
        if (err[2]) ec2 <= ec2 + 1;
        if (frame_valid && !vld_prev) vrise <= vrise + 1;
        vld_prev <= frame_valid;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FB-1:0] rnd_vec();
        logic [FB-1:0] v = '0;
        for (int i = 0; i < 13; i++) v = {v[FB-33:0], 32'($urandom)};
        return v;
    endfunction

    // Reference outcome: 0 accepted, 1 short/rejected (err[0]), 2 long (err[1]).
    function automatic int outcome(input int n, input logic [7:0] ks);
        if (n < FB) return 1;
        if (n > FB) return 2;
`ifdef SPI_FRAME_RX_KEYCHK_EN
        if (!(ks inside {8'h10, 8'h18, 8'h20})) return 1;
`endif
        return 0;
    endfunction

    // SPI master, mode 0, 100 ns sclk period. miso is sampled just before each rising edge.
    task automatic send(input logic [FB-1:0] f, input int n, input bit raise_cs, output logic [FB-1:0] cap);
        cap = '0;
        @(negedge clk);
        cs = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            mosi = (i < FB) ? f[FB-1-i] : 1'($urandom);
            #50;
            if (i < FB) cap[FB-1-i] = miso;
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
        if (raise_cs) begin
            #50;
            cs = 1'b1;
        end
    endtask

    // Sends one frame with tx as the response and checks the full outcome.
    task automatic do_frame(input string tag, input logic [FB-1:0] f, input int n,
                            input logic [FB-1:0] tx, input bit release_frame);
        int            e0, e1, e2, vr, lat, exp_o;
        logic [FB-1:0] cap, ones, mask;
        ones  = '1;
        mask  = ~(ones >> n);
        exp_o = outcome(n, f[FB-129 -: 8]);
        tx_data = tx;
        @(negedge clk); #1;
        e0 = ec0; e1 = ec1; e2 = ec2; vr = vrise;
        send(f, n, 1'b1, cap);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_valid && lat < 0) lat = k;
        end
        #1;
        check({tag, "_miso"}, cap, tx & mask);
        check({tag, "_err0"}, FB'(ec0 - e0), FB'(exp_o == 1));
        check({tag, "_err1"}, FB'(ec1 - e1), FB'(exp_o == 2));
        check({tag, "_err2"}, FB'(ec2 - e2), '0);
        check({tag, "_vrise"}, FB'(vrise - vr), FB'(exp_o == 0));
        if (exp_o == 0) begin
            check({tag, "_lat_le5"}, FB'(lat >= 1 && lat <= 5), FB'(1));
            check({tag, "_data"}, frame_data, f);
            if (release_frame) begin
                frame_ready = 1'b1;
                @(negedge clk);
                check({tag, "_vld_drop"}, FB'(frame_valid), '0);
                frame_ready = 1'b0;
            end
        end else begin
            check({tag, "_idle"}, FB'({busy, frame_valid}), '0);
        end
    endtask

    initial begin
        logic [FB-1:0] f, fa, tx, cap;
        int            e0, e1, e2, vr;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso",  FB'(miso), '0);
        check("rst_valid", FB'(frame_valid), '0);
        check("rst_busy",  FB'(busy), '0);
        check("rst_err",   FB'(err), '0);
        check("rst_data",  frame_data, '0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Known-answer frame with fixed miso response
        f  = {128'h00112233445566778899aabbccddeeff, 8'h10,
              128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        tx = rnd_vec();
        tx[FB-1 -: 128] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        do_frame("kat", f, FB, tx, 1'b1);

        // Random frames, key_size drawn from legal and arbitrary values
        for (int r = 0; r < 2; r++) begin
            f = rnd_vec();
            case ($urandom_range(0, 3))
                0: f[FB-129 -: 8] = 8'h10;
                1: f[FB-129 -: 8] = 8'h18;
                2: f[FB-129 -: 8] = 8'h20;
                default: f[FB-129 -: 8] = 8'($urandom);
            endcase
            do_frame("rnd", f, FB, rnd_vec(), 1'b1);
        end

        // Short frame
        do_frame("short", rnd_vec(), 200, rnd_vec(), 1'b1);

        // Long frame, then a normal one must still be accepted
        f = rnd_vec();
        f[FB-129 -: 8] = 8'h20;
        do_frame("long", f, FB + 1, rnd_vec(), 1'b1);
        do_frame("after_long", f, FB, rnd_vec(), 1'b1);

        // Overrun: first frame held, second window ignored
        fa = rnd_vec();
        fa[FB-129 -: 8] = 8'h18;
        do_frame("ovr_a", fa, FB, rnd_vec(), 1'b0);
        tx_data = rnd_vec();
        @(negedge clk); #1;
        e0 = ec0; e2 = ec2; vr = vrise;
        send(rnd_vec(), FB, 1'b1, cap);
        repeat (10) @(negedge clk);
        #1;
        check("ovr_err2",  FB'(ec2 - e2), FB'(1));
        check("ovr_err0",  FB'(ec0 - e0), '0);
        check("ovr_keep",  frame_data, fa);
        check("ovr_valid", FB'(frame_valid), FB'(1));
        check("ovr_vrise", FB'(vrise - vr), '0);
        check("ovr_miso0", cap, '0);
        frame_ready = 1'b1;
        @(negedge clk);
        check("ovr_drop", FB'(frame_valid), '0);
        frame_ready = 1'b0;

        // Illegal key_size: rejected only when the key check is built in
        f = rnd_vec();
        f[FB-129 -: 8] = 8'h11;
        do_frame("ks11", f, FB, rnd_vec(), 1'b1);

        // Reset in the middle of a frame
        tx = rnd_vec();
        tx[FB-1] = 1'b1;
        tx_data = tx;
        @(negedge clk); #1;
        e0 = ec0; e1 = ec1; e2 = ec2; vr = vrise;
        send(rnd_vec(), 100, 1'b0, cap);
        reset = 1'b0;
        #1;
        check("mid_rst_out", FB'({miso, frame_valid, busy, err}), '0);
        check("mid_rst_data", frame_data, '0);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("mid_rst_noerr", FB'((ec0 - e0) + (ec1 - e1) + (ec2 - e2)), '0);
        check("mid_rst_novld", FB'(vrise - vr), '0);
        check("mid_rst_idle", FB'({busy, frame_valid}), '0);
        f = rnd_vec();
        f[FB-129 -: 8] = 8'h10;
        do_frame("post_rst", f, FB, rnd_vec(), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
